// File: rtl/rv32i_instr_encoder_loader.sv
// rv32i_instr_encoder_loader
// Packs an operation given in the 6-bit alu_control encoding, plus register
// and immediate fields, into a 32-bit RV32I instruction word and streams the
// words into instruction memory at consecutive word addresses.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i / finish_i        one-cycle pulses opening / closing a load session
//   in_valid_i / in_ready_o   operation handshake
//   op_code_i, rd_i, rs1_i,   operation and fields (imm_i pre-shifted,
//   rs2_i, imm_i              bit 0 ignored for B/J, imm_i[31:12] for U)
//   imem_we_o/addr_o/wdata_o  instruction-memory write port
//   word_count_o, full_o      words written this session, count == DEPTH
//   illegal_o                 sticky: an unsupported op_code was accepted
//   done_o                    one-cycle pulse when a session closes
//
// state  | meaning
// S_IDLE | no session open, waiting for start
// S_LOAD | session open, accepting operations
// S_FULL | DEPTH words written, waiting for finish
module rv32i_instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [5:0]        op_code_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              full_o,
    output logic              illegal_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic              illegal_q, illegal_d;
    logic              done_q, done_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic        accept;
    logic        unused_imm;

    // Bit 0 of a B/J immediate is implied zero.
    assign unused_imm = imm_i[0];

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        f3        = 3'b000;
        f7        = 7'h00;
        imm12     = imm_i[11:0];
        case (op_code_i) inside
            [6'h01:6'h0A]: begin
                case (op_code_i)
                    6'h01, 6'h02: f3 = 3'b000;
                    6'h03:        f3 = 3'b001;
                    6'h04:        f3 = 3'b010;
                    6'h05:        f3 = 3'b011;
                    6'h06:        f3 = 3'b100;
                    6'h07, 6'h08: f3 = 3'b101;
                    6'h09:        f3 = 3'b110;
                    default:      f3 = 3'b111;
                endcase
                if (op_code_i == 6'h02 || op_code_i == 6'h08) f7 = 7'h20;
                enc_word = {f7, rs2_i, rs1_i, f3, rd_i, 7'b0110011};
            end
            [6'h0B:6'h12]: begin
                f3 = 3'(op_code_i - 6'h0B);
                // Shift-immediates carry only the 5-bit shift amount.
                if (op_code_i == 6'h0C || op_code_i == 6'h10) imm12 = {7'b0, imm_i[4:0]};
                enc_word = {imm12, rs1_i, f3, rd_i, 7'b0010011};
            end
            [6'h13:6'h17]: begin
                f3       = 3'(op_code_i - 6'h13);
                enc_word = {imm_i[11:0], rs1_i, f3, rd_i, 7'b0000011};
            end
            [6'h18:6'h1A]: begin
                case (op_code_i)
                    6'h18:   f3 = 3'b010;
                    6'h19:   f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
                enc_word = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], 7'b0100011};
            end
            [6'h1B:6'h20]: begin
                case (op_code_i)
                    6'h1B:   f3 = 3'b000;
                    6'h1C:   f3 = 3'b001;
                    6'h1D:   f3 = 3'b010;
                    6'h1E:   f3 = 3'b110;
                    6'h1F:   f3 = 3'b101;
                    default: f3 = 3'b100;
                endcase
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                            imm_i[4:1], imm_i[11], 7'b1100011};
            end
            6'h21: enc_word = {imm_i[31:12], rd_i, 7'b0110111};
            6'h22: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, 7'b1101111};
            default: enc_legal = 1'b0;
        endcase
    end

    assign full_o     = (count_q == DEPTH_C);
    assign in_ready_o = (state_q == S_LOAD) && !full_o && !finish_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        we_d      = 1'b0;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    ptr_d     = BASE_C;
                    count_d   = '0;
                    illegal_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (enc_legal) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                if (finish_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (count_d == DEPTH_C) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (finish_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= BASE_C;
            addr_q    <= BASE_C;
            wdata_q   <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = count_q;
    assign illegal_o    = illegal_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_rv32i_instr_encoder_loader.sv
module tb_rv32i_instr_encoder_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 6;
    localparam int BASE   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [5:0]        op = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]       imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full, illegal, done;

    int total = 0;
    int passed = 0;

    rv32i_instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .finish_i(finish),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .op_code_i(op),
        .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .word_count_o(word_count), .full_o(full), .illegal_o(illegal), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference encoder built from field arithmetic: {legal, word}.
    function automatic logic [32:0] ref_encode(input logic [5:0] o6, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2,
                                               input logic [31:0] im);
        logic [31:0] f3, f7, immf, R, S1, S2;
        logic [29:0] rtab;
        logic [17:0] btab;
        int o;
        o = int'(o6);
        R = 32'(d); S1 = 32'(s1); S2 = 32'(s2);
        rtab = {3'd7, 3'd6, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        btab = {3'd4, 3'd5, 3'd6, 3'd2, 3'd1, 3'd0};
        if (o >= 1 && o <= 10) begin
            f3 = 32'((rtab >> (3 * (o - 1))) & 30'h7);
            f7 = (o == 2 || o == 8) ? 32'h20 : 32'h0;
            return {1'b1, (f7 << 25) | (S2 << 20) | (S1 << 15) | (f3 << 12) | (R << 7) | 32'h33};
        end else if (o >= 11 && o <= 18) begin
            f3   = 32'(o - 11);
            immf = (o == 12 || o == 16) ? (im & 32'h1f) : (im & 32'hfff);
            return {1'b1, (immf << 20) | (S1 << 15) | (f3 << 12) | (R << 7) | 32'h13};
        end else if (o >= 19 && o <= 23) begin
            f3 = 32'(o - 19);
            return {1'b1, ((im & 32'hfff) << 20) | (S1 << 15) | (f3 << 12) | (R << 7) | 32'h03};
        end else if (o >= 24 && o <= 26) begin
            f3 = (o == 24) ? 32'd2 : (o == 25) ? 32'd6 : 32'd7;
            return {1'b1, (((im >> 5) & 32'h7f) << 25) | (S2 << 20) | (S1 << 15) |
                          (f3 << 12) | ((im & 32'h1f) << 7) | 32'h23};
        end else if (o >= 27 && o <= 32) begin
            f3 = 32'((btab >> (3 * (o - 27))) & 18'h7);
            return {1'b1, (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3f) << 25) |
                          (S2 << 20) | (S1 << 15) | (f3 << 12) |
                          (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63};
        end else if (o == 33) begin
            return {1'b1, (im & 32'hfffff000) | (R << 7) | 32'h37};
        end else if (o == 34) begin
            return {1'b1, (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3ff) << 21) |
                          (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hff) << 12) |
                          (R << 7) | 32'h6f};
        end
        return {1'b0, 32'h0};
    endfunction

    // Control-unit style decode back to alu_control, for the round-trip check.
    function automatic logic [5:0] ref_decode(input logic [31:0] w);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        case (opc)
            7'h33: case (f3)
                3'd0: return (f7 == 7'h20) ? 6'h02 : 6'h01;
                3'd1: return 6'h03;
                3'd2: return 6'h04;
                3'd3: return 6'h05;
                3'd4: return 6'h06;
                3'd5: return (f7 == 7'h20) ? 6'h08 : 6'h07;
                3'd6: return 6'h09;
                default: return 6'h0A;
            endcase
            7'h13: return 6'h0B + 6'(f3);
            7'h03: return 6'h13 + 6'(f3);
            7'h23: return (f3 == 3'd2) ? 6'h18 : (f3 == 3'd6) ? 6'h19 : 6'h1A;
            7'h63: case (f3)
                3'd0: return 6'h1B;
                3'd1: return 6'h1C;
                3'd2: return 6'h1D;
                3'd4: return 6'h20;
                3'd5: return 6'h1F;
                3'd6: return 6'h1E;
                default: return 6'h00;
            endcase
            7'h37: return 6'h21;
            7'h6f: return 6'h22;
            default: return 6'h00;
        endcase
    endfunction

    // Behavioural model: session flag, write count, pointer, pending write.
    logic        m_open, m_we, m_done, m_illegal;
    int          m_count, m_ptr, m_addr;
    logic [31:0] m_wdata;
    logic [5:0]  m_op;

    always @(posedge clk or negedge rst_n) begin
        logic [32:0] e;
        logic        rdy;
        if (!rst_n) begin
            m_open = 0; m_we = 0; m_done = 0; m_illegal = 0;
            m_count = 0; m_ptr = BASE; m_addr = BASE; m_wdata = '0; m_op = '0;
        end else begin
            rdy    = m_open && (m_count < DEPTH) && !finish;
            e      = ref_encode(op, rd, rs1, rs2, imm);
            m_we   = 0;
            m_done = m_open && finish;
            if (in_valid && rdy) begin
                if (e[32]) begin
                    m_we    = 1;
                    m_addr  = m_ptr;
                    m_wdata = e[31:0];
                    m_op    = op;
                    m_ptr   = (m_ptr + 1) % (1 << ADDR_W);
                    m_count = m_count + 1;
                end else begin
                    m_illegal = 1;
                end
            end
            if (!m_open) begin
                if (start) begin
                    m_open = 1; m_count = 0; m_ptr = BASE; m_illegal = 0;
                end
            end else if (finish) begin
                m_open = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("we", 32'(imem_we), 32'(m_we));
            if (m_we) begin
                check("addr", 32'(imem_addr), 32'(m_addr));
                check("wdata", imem_wdata, m_wdata);
                check("roundtrip", 32'(ref_decode(imem_wdata)), 32'(m_op));
            end
            check("word_count", 32'(word_count), 32'(m_count));
            check("full", 32'(full), 32'(m_count == DEPTH));
            check("illegal", 32'(illegal), 32'(m_illegal));
            check("done", 32'(done), 32'(m_done));
            check("in_ready", 32'(in_ready), 32'(m_open && (m_count < DEPTH) && !finish));
        end
    end

    task automatic send(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im,
                        input logic exp_we, input logic [31:0] exp_w, input string name);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
        @(posedge clk); #1;
        check({name, " we"}, 32'(imem_we), 32'(exp_we));
        if (exp_we) check({name, " wdata"}, imem_wdata, exp_w);
    endtask

    initial begin
        int nwe;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst we", 32'(imem_we), 32'h0);
        check("rst addr", 32'(imem_addr), 32'(BASE));
        check("rst wdata", imem_wdata, 32'h0);
        check("rst count", 32'(word_count), 32'h0);
        check("rst full", 32'(full), 32'h0);
        check("rst illegal", 32'(illegal), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        send(6'h01, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3, "add");
        check("add addr", 32'(imem_addr), 32'(BASE));
        check("add count", 32'(word_count), 32'd1);
        send(6'h3F, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0, "op3f");
        check("op3f illegal", 32'(illegal), 32'd1);
        check("op3f count", 32'(word_count), 32'd1);
        send(6'h02, 5'd5, 5'd6, 5'd7, 32'h0, 1'b1, 32'h407302B3, "sub");
        send(6'h0B, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, "addi");
        send(6'h21, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345137, "lui");
        send(6'h1B, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463, "beq");
        send(6'h22, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF, "jal");
        check("jal addr wrap", 32'(imem_addr), 32'd2);
        check("last count", 32'(word_count), 32'(DEPTH));
        check("last full", 32'(full), 32'd1);
        check("last in_ready", 32'(in_ready), 32'd0);
        send(6'h01, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0, "over1");
        send(6'h0B, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0, "over2");
        in_valid = 1'b0;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        check("done pulse", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done low", 32'(done), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart illegal", 32'(illegal), 32'd0);
        check("restart count", 32'(word_count), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom % 40) == 0;
            finish   = ($urandom % 35) == 0;
            in_valid = ($urandom % 4) != 0;
            if (($urandom % 10) < 8) op = 6'($urandom_range(1, 34));
            else if (($urandom % 5) == 0) op = 6'h00;
            else op = 6'($urandom_range(35, 63));
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            imm = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(6'h01, 5'd4, 5'd2, 5'd3, 32'h0, 1'b1, 32'h003102B3 & 32'h0 | 32'h00310233, "pre-reset");
        #1 rst_n = 1'b0;
        #1;
        check("async we", 32'(imem_we), 32'd0);
        check("async count", 32'(word_count), 32'd0);
        check("async in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        nwe = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_we) nwe++;
        end
        check("no write after reset", 32'(nwe), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
